// File: rtl/auth_msg_arbiter.sv
`default_nettype none
// auth_msg_arbiter: round-robin owner of the single authentication transmit path.
// Grants one controller, forwards its message, then routes the reply or flags a timeout.
module auth_msg_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int MSG_W       = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*MSG_W-1:0] req_msg,
  output logic [NUM_REQ-1:0]       ack_req,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     tx_valid,
  output logic [MSG_W-1:0]         tx_msg,
  input  logic                     tx_ready,
  input  logic                     rsp_valid,
  output logic [NUM_REQ-1:0]       rsp_to,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [2:0]               err_id
);

  localparam int              IDX_W     = $clog2(NUM_REQ);
  localparam logic [15:0]     CNT_LAST  = 16'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W:0]  NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SEND     = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [15:0]        cnt_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               tx_valid_q;
  logic [MSG_W-1:0]   tx_msg_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] rsp_to_q;
  logic               busy_q;
  logic               tmo_q;
  logic [2:0]         err_id_q;

  logic [MSG_W-1:0]   msg_arr [NUM_REQ];
  logic [IDX_W:0]     scan_d;
  logic               win_vld_d;
  logic [IDX_W-1:0]   win_idx_d;
  logic [IDX_W-1:0]   rr_next_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign msg_arr[i] = req_msg[i*MSG_W +: MSG_W];
  end

  // Search upward from rr_ptr with wrap; the first set request wins.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    scan_d    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_d = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (scan_d >= NUM_REQ_W) scan_d = scan_d - NUM_REQ_W;
      if (!win_vld_d && req[scan_d[IDX_W-1:0]]) begin
        win_vld_d = 1'b1;
        win_idx_d = scan_d[IDX_W-1:0];
      end
    end
  end

  assign rr_next_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_msg_q   <= '0;
      ack_q      <= '0;
      rsp_to_q   <= '0;
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
      err_id_q   <= '0;
    end else begin
      ack_q    <= '0;
      rsp_to_q <= '0;
      tmo_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            owner_q    <= win_idx_d;
            grant_q    <= NUM_REQ'(1) << win_idx_d;
            tx_msg_q   <= msg_arr[win_idx_d];
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            ack_q      <= grant_q;
            cnt_q      <= '0;
            state_q    <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          // A response on the final wait cycle beats the timeout.
          if (rsp_valid) begin
            rsp_to_q <= grant_q;
            rr_ptr_q <= rr_next_d;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            tmo_q    <= 1'b1;
            err_id_q <= 3'(owner_q);
            rr_ptr_q <= rr_next_d;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack_req     = ack_q;
  assign grant       = grant_q;
  assign tx_valid    = tx_valid_q;
  assign tx_msg      = tx_msg_q;
  assign rsp_to      = rsp_to_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_q;
  assign err_id      = err_id_q;

endmodule
`default_nettype wire

// File: tb/tb_auth_msg_arbiter.sv
`default_nettype none
// tb_auth_msg_arbiter: randomized transactions predicted by a transaction-level model;
// expected events are queued with their cycle and checked by an independent monitor.
module tb_auth_msg_arbiter;

  localparam int NUM_REQ = 3;
  localparam int MSG_W   = 64;
  localparam int TMO     = 8;
  localparam int NTXN    = 150;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*MSG_W-1:0] req_msg;
  logic [NUM_REQ-1:0]       ack_req;
  logic [NUM_REQ-1:0]       grant;
  logic                     tx_valid;
  logic [MSG_W-1:0]         tx_msg;
  logic                     tx_ready;
  logic                     rsp_valid;
  logic [NUM_REQ-1:0]       rsp_to;
  logic                     busy;
  logic                     timeout_err;
  logic [2:0]               err_id;

  auth_msg_arbiter #(.NUM_REQ(NUM_REQ), .MSG_W(MSG_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_msg(req_msg), .ack_req(ack_req),
    .grant(grant), .tx_valid(tx_valid), .tx_msg(tx_msg), .tx_ready(tx_ready),
    .rsp_valid(rsp_valid), .rsp_to(rsp_to), .busy(busy),
    .timeout_err(timeout_err), .err_id(err_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [63:0] val;
    logic [63:0] aux;
  } ev_t;

  ev_t gq[$];  // grant/message presentation
  ev_t aq[$];  // ack_req pulses
  ev_t rq[$];  // rsp_to pulses
  ev_t tq[$];  // timeout pulses, val = owner index
  ev_t lq[$];  // levels: val = {busy, tx_valid}, aux = grant

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Model state: requester levels, their messages, and the round-robin start index.
  logic [NUM_REQ-1:0] req_r;
  logic [MSG_W-1:0]   msg_r [NUM_REQ];
  int                 rr;

  function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
    for (int k = 0; k < NUM_REQ; k++)
      if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    req = req_r;
    for (int i = 0; i < NUM_REQ; i++) req_msg[i*MSG_W +: MSG_W] = msg_r[i];
  endtask

  task automatic add_reqs(input logic [NUM_REQ-1:0] excl, input bit force_nz);
    do begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_r[i] && !excl[i] && (($urandom % 3) == 0)) begin
          msg_r[i] = {$urandom, $urandom};
          req_r[i] = 1'b1;
        end
      end
    end while (force_nz && req_r == '0);
  endtask

  task automatic check_reset_outputs();
    check("rst_grant", grant, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_msg", tx_msg, 0);
    check("rst_ack_req", ack_req, 0);
    check("rst_rsp_to", rsp_to, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_err_id", err_id, 0);
  endtask

  task automatic do_txn(input bit do_rst);
    int w, s, d, ca, ce, g, k, n;
    logic [63:0] oh;
    rsp_valid = 1'b0;
    if (req_r == '0) begin
      g = $urandom_range(0, 2);
      apply();
      repeat (g) step();
      add_reqs('0, 1'b1);
    end
    apply();
    w  = pick(req_r, rr);
    oh = 64'd1 << w;
    gq.push_back('{cyc + 1, oh, msg_r[w]});
    lq.push_back('{cyc + 1, 64'b11, oh});
    step();
    // SEND: optional backpressure, ignored response noise, owner may drop its level
    s = (($urandom % 6) == 0) ? 10 : int'($urandom_range(0, 3));
    repeat (s) begin
      tx_ready  = 1'b0;
      rsp_valid = (($urandom % 3) == 0);
      if (($urandom % 4) == 0) req_r[w] = 1'b0;
      add_reqs(NUM_REQ'(oh), 1'b0);
      apply();
      step();
    end
    tx_ready  = 1'b1;
    rsp_valid = (($urandom % 3) == 0);
    ca = cyc + 1;
    aq.push_back('{ca, oh, 0});
    lq.push_back('{ca, 64'b10, oh});
    step();
    tx_ready  = ($urandom % 2);
    rsp_valid = 1'b0;
    req_r[w]  = 1'b0;
    apply();
    if (do_rst) begin
      k = $urandom_range(0, TMO - 2);
      repeat (k) step();
      reset = 1'b1;
      req_r = '0;
      apply();
      step();
      reset     = 1'b0;
      rsp_valid = 1'b1;
      check_reset_outputs();
      rr = 0;
      step();
      rsp_valid = 1'b0;
      return;
    end
    case ($urandom % 4)
      0:       d = TMO + 5;
      1:       d = TMO - 1;
      default: d = $urandom_range(0, TMO - 2);
    endcase
    if (d <= TMO - 1) begin
      ce = ca + d + 1;
      n  = d + 1;
      rq.push_back('{ce, oh, 0});
    end else begin
      ce = ca + TMO;
      n  = TMO;
      tq.push_back('{ce, 64'(w), 0});
    end
    lq.push_back('{ce, 64'b00, 0});
    for (int j = 0; j < n; j++) begin
      rsp_valid = (j == d);
      if (($urandom % 4) == 0) add_reqs('0, 1'b0);
      apply();
      step();
    end
    rsp_valid = (d > TMO - 1) && (($urandom % 2) == 1);
    rr = (w + 1) % NUM_REQ;
  endtask

  // Monitor: compares whenever the DUT pulses or the scoreboard expects something now.
  initial begin
    ev_t e;
    ev_t cur;
    logic prev_tv;
    prev_tv = 1'b0;
    cur     = '{0, 0, 0};
    forever begin
      @(negedge clk);
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        cur = gq.pop_front();
        check("tx_valid_rise", tx_valid, 1);
        check("grant", grant, cur.val);
        check("tx_msg", tx_msg, cur.aux);
      end else if (tx_valid && !prev_tv) begin
        check("tx_valid_unexpected", tx_valid, 0);
      end else if (tx_valid) begin
        check("grant_hold", grant, cur.val);
        check("tx_msg_hold", tx_msg, cur.aux);
      end
      prev_tv = tx_valid;

      if (aq.size() > 0 && aq[0].cyc == cyc) begin
        e = aq.pop_front();
        check("ack_req", ack_req, e.val);
      end else if (ack_req != '0) check("ack_req_unexpected", ack_req, 0);

      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        e = rq.pop_front();
        check("rsp_to", rsp_to, e.val);
        check("no_timeout_on_rsp", timeout_err, 0);
      end else if (rsp_to != '0) check("rsp_to_unexpected", rsp_to, 0);

      if (tq.size() > 0 && tq[0].cyc == cyc) begin
        e = tq.pop_front();
        check("timeout_err", timeout_err, 1);
        check("err_id", err_id, e.val);
      end else if (timeout_err) check("timeout_err_unexpected", timeout_err, 0);

      if (lq.size() > 0 && lq[0].cyc == cyc) begin
        e = lq.pop_front();
        check("busy_txvalid", {busy, tx_valid}, e.val);
        check("grant_level", grant, e.aux);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_msg   = '0;
    tx_ready  = 1'b0;
    rsp_valid = 1'b0;
    req_r     = '0;
    rr        = 0;
    for (int i = 0; i < NUM_REQ; i++) msg_r[i] = '0;
    step();
    step();
    check_reset_outputs();
    reset = 1'b0;
    for (int t = 0; t < NTXN; t++) do_txn(t == 50 || t == 110);
    rsp_valid = 1'b0;
    req_r     = '0;
    apply();
    repeat (4) step();
    check("pending_grant_events", gq.size(), 0);
    check("pending_ack_events", aq.size(), 0);
    check("pending_rsp_events", rq.size(), 0);
    check("pending_timeout_events", tq.size(), 0);
    check("pending_level_events", lq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/auth_msg_arbiter.md
Name: auth_msg_arbiter

Overview:
- Shares the single authentication transmit path between several initiator-side message controllers, such as the digest, certificate-chain and challenge controllers.
- Each controller presents a complete request message; the arbiter grants one requester at a time (round-robin), drives the message to the transmitter and waits for the responder's reply.
- It routes the response-arrival strobe back to the owning controller, or flags a timeout.
- Only one authentication transaction is outstanding on the bus at any time.

Parameters:
- NUM_REQ, 3, number of requesting controllers (2..8).
- MSG_W, 64, width of one request message (header+payload) in bits.
- TIMEOUT_CYC, 255, maximum cycles in WAIT_RSP before timeout (1..65535).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester message-ready level; held until ack_req.
- req_msg  in  NUM_REQ*MSG_W  messages; requester i occupies bits [i*MSG_W +: MSG_W].
- ack_req  out  NUM_REQ  one-cycle one-hot pulse: message of requester i accepted by transmitter.
- grant  out  NUM_REQ  one-hot current owner; zero in IDLE.
- tx_valid  out  1  message valid toward transmitter.
- tx_msg  out  MSG_W  registered copy of the granted message.
- tx_ready  in  1  transmitter accepts tx_msg when tx_valid && tx_ready.
- rsp_valid  in  1  one-cycle strobe: response for the outstanding request received.
- rsp_to  out  NUM_REQ  one-cycle one-hot pulse routing rsp_valid to the owner.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse on response timeout.
- err_id  out  3  index of the owner at the last timeout; holds until the next timeout.

Behaviour:
- Reset (synchronous, takes priority in every state, including mid-transaction):
  - state=IDLE, rr_ptr=0, wait counter=0.
  - All outputs 0: grant, tx_valid, tx_msg, ack_req, rsp_to, busy, timeout_err, err_id.
  - An in-flight message is abandoned; no ack or rsp pulse is produced.
- States: IDLE, SEND, WAIT_RSP.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - Next edge: latch req_msg of the winner into tx_msg, set grant one-hot, tx_valid=1, go to SEND.
  - Latency is one cycle from req sampled high to tx_valid high.
- SEND:
  - tx_valid=1 and tx_msg stays stable until the handshake.
  - On an edge with tx_ready=1: tx_valid->0, ack_req[owner] pulses for exactly the following cycle, counter cleared, go to WAIT_RSP.
  - Deassertion of req[owner] during SEND is ignored; the latched message is still sent.
  - rsp_valid in SEND is ignored.
- WAIT_RSP:
  - Counter increments every cycle.
  - rsp_valid=1: rsp_to[owner] pulses for the next cycle, rr_ptr=(owner+1) mod NUM_REQ, grant->0, go to IDLE.
  - Counter reaches TIMEOUT_CYC-1 without rsp_valid: timeout_err pulses, err_id=owner, rr_ptr=(owner+1) mod NUM_REQ, go to IDLE.
  - If rsp_valid coincides with the timeout cycle, the response wins and there is no timeout_err.
- Fairness:
  - rr_ptr advances only on transaction completion (response or timeout), so every continuously requesting controller is served within NUM_REQ transactions.
  - IDLE lasts at least one cycle between transactions, so back-to-back requests from different controllers are separated by one IDLE cycle.
- Requests arriving while busy: no effect until IDLE; req is level-sensitive and never lost.
- Widths:
  - Wait counter is 16 bits and never wraps, because it is cleared on exit from WAIT_RSP.
  - err_id is zero-extended index.
- ack_req, rsp_to and timeout_err are registered outputs; at most one bit of ack_req/rsp_to is set at once.

Test Plan:
- Single request: NUM_REQ=3, req=3'b010, req_msg[127:64]=64'hA5A5_0001_0000_00FF, tx_ready=1 -> tx_valid at cycle 1 with tx_msg=64'hA5A5_0001_0000_00FF, grant=3'b010, ack_req=3'b010 one cycle; rsp_valid 5 cycles later -> rsp_to=3'b010 one cycle, busy->0.
- Round-robin: req=3'b111 held, responses immediate -> grant order 001, 010, 100, 001; each requester served once per three transactions.
- Backpressure: tx_ready=0 for 10 cycles -> tx_valid stays 1, tx_msg stable, no ack_req; tx_ready=1 -> ack_req pulse next cycle.
- Timeout: TIMEOUT_CYC=8, owner=2, no rsp_valid -> timeout_err pulse 8 cycles after entering WAIT_RSP, err_id=2, next grant searches from index 0.
- Response/timeout collision: rsp_valid on the timeout cycle -> rsp_to pulse, timeout_err stays 0.
- Reset mid-WAIT_RSP: assert reset one cycle -> all outputs 0, state IDLE, rr_ptr=0; a late rsp_valid afterwards produces no rsp_to.
